// File: rtl/rtc_bus_arbiter_if.sv
// Bus bundle between the three bus controllers (init, write, read),
// the shared bus-cycle engine and the arbiter that owns the bus.
// The slave modport is the arbiter's view; master is the controllers' side.
interface rtc_bus_arbiter_if;
    // Requests and completions from the controllers
    logic       Inicio_I;
    logic       Inicio_E;
    logic       Inicio_L;
    logic       Fin_I;
    logic       Fin_E;
    logic       Fin_L;

    // Per-controller bus-cycle parameters
    logic [3:0] Addr_I;
    logic [3:0] Addr_E;
    logic [3:0] Addr_L;
    logic       Op_I;
    logic       Op_E;
    logic       Op_L;
    logic       AD_I;
    logic       AD_E;
    logic       AD_L;

    // Completion pulse from the shared bus-cycle engine
    logic       Final_WR;

    // Arbiter outputs
    logic       Gnt_I;
    logic       Gnt_E;
    logic       Gnt_L;
    logic       Final_WR_I;
    logic       Final_WR_E;
    logic       Final_WR_L;
    logic [3:0] Addr;
    logic       Op;
    logic       AD;
    logic       Busy;
    logic       Err_TO;

    modport slave (
        input  Inicio_I, Inicio_E, Inicio_L,
        input  Fin_I, Fin_E, Fin_L,
        input  Addr_I, Addr_E, Addr_L,
        input  Op_I, Op_E, Op_L,
        input  AD_I, AD_E, AD_L,
        input  Final_WR,
        output Gnt_I, Gnt_E, Gnt_L,
        output Final_WR_I, Final_WR_E, Final_WR_L,
        output Addr, Op, AD,
        output Busy, Err_TO
    );

    modport master (
        output Inicio_I, Inicio_E, Inicio_L,
        output Fin_I, Fin_E, Fin_L,
        output Addr_I, Addr_E, Addr_L,
        output Op_I, Op_E, Op_L,
        output AD_I, AD_E, AD_L,
        output Final_WR,
        input  Gnt_I, Gnt_E, Gnt_L,
        input  Final_WR_I, Final_WR_E, Final_WR_L,
        input  Addr, Op, AD,
        input  Busy, Err_TO
    );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Arbiter for the shared RTC bus-cycle engine.
// Init requests have absolute priority; write and read alternate when both
// are pending. Every grant ends in a one-cycle GAP state, and a grant held
// for TIMEOUT_CYC cycles without completion is forcibly released with an
// Err_TO pulse. Err_TO is registered and therefore shows up in the GAP cycle
// that follows the timeout release.
module rtc_bus_arbiter #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 11
) (
    input  logic             clk,
    input  logic             reset,
    rtc_bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        G_INIT  = 3'd1,
        G_WRITE = 3'd2,
        G_READ  = 3'd3,
        GAP     = 3'd4
    } state_t;

    // Counter value seen in the last cycle a grant may be held
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            last_l_q, last_l_d;   // 1: read (L) was served last, 0: write (E)
    logic            err_to_q, err_to_d;

    logic            own_req;
    logic            own_fin;
    logic            to_hit;

    assign to_hit = (to_cnt_q == TO_LAST);

    // Select the request level and finish pulse of whoever currently holds the grant
    always_comb begin
        own_req = 1'b0;
        own_fin = 1'b0;
        case (state_q)
            G_INIT: begin
                own_req = bus.Inicio_I;
                own_fin = bus.Fin_I;
            end
            G_WRITE: begin
                own_req = bus.Inicio_E;
                own_fin = bus.Fin_E;
            end
            G_READ: begin
                own_req = bus.Inicio_L;
                own_fin = bus.Fin_L;
            end
            default: begin
                own_req = 1'b0;
                own_fin = 1'b0;
            end
        endcase
    end

    // Next-state logic: arbitration in IDLE, release conditions in grant states
    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        last_l_d = last_l_q;
        err_to_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Counter stays cleared here so every grant starts from zero
                if (bus.Inicio_I) begin
                    state_d = G_INIT;
                end else if (bus.Inicio_E && bus.Inicio_L) begin
                    if (last_l_q) begin
                        state_d  = G_WRITE;
                        last_l_d = 1'b0;
                    end else begin
                        state_d  = G_READ;
                        last_l_d = 1'b1;
                    end
                end else if (bus.Inicio_E) begin
                    state_d  = G_WRITE;
                    last_l_d = 1'b0;
                end else if (bus.Inicio_L) begin
                    state_d  = G_READ;
                    last_l_d = 1'b1;
                end
            end
            G_INIT, G_WRITE, G_READ: begin
                if (own_fin || !own_req || to_hit) begin
                    state_d  = GAP;
                    // A finish in the timeout cycle counts as a normal completion
                    err_to_d = to_hit && !own_fin;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, timeout counter, fairness flag and error pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            last_l_q <= 1'b1;
            err_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            last_l_q <= last_l_d;
            err_to_q <= err_to_d;
        end
    end

    // Grants decode straight from the state register; bus mux and Final_WR routing follow them
    always_comb begin
        bus.Gnt_I      = (state_q == G_INIT);
        bus.Gnt_E      = (state_q == G_WRITE);
        bus.Gnt_L      = (state_q == G_READ);
        bus.Busy       = (state_q == G_INIT) || (state_q == G_WRITE) || (state_q == G_READ);
        bus.Err_TO     = err_to_q;
        bus.Final_WR_I = bus.Final_WR && (state_q == G_INIT);
        bus.Final_WR_E = bus.Final_WR && (state_q == G_WRITE);
        bus.Final_WR_L = bus.Final_WR && (state_q == G_READ);
        bus.Addr       = 4'h0;
        bus.Op         = 1'b0;
        bus.AD         = 1'b0;
        case (state_q)
            G_INIT: begin
                bus.Addr = bus.Addr_I;
                bus.Op   = bus.Op_I;
                bus.AD   = bus.AD_I;
            end
            G_WRITE: begin
                bus.Addr = bus.Addr_E;
                bus.Op   = bus.Op_E;
                bus.AD   = bus.AD_E;
            end
            G_READ: begin
                bus.Addr = bus.Addr_L;
                bus.Op   = bus.Op_L;
                bus.AD   = bus.AD_L;
            end
            default: begin
                bus.Addr = 4'h0;
                bus.Op   = 1'b0;
                bus.AD   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: a per-cycle owner/holding-time model checks every
// output each cycle, directed scenarios pin the model with literal values,
// then randomized traffic (including resets) runs against the same model.
module tb_rtc_bus_arbiter;
    localparam int TO_CYC = 16;

    logic clk;
    logic reset;
    rtc_bus_arbiter_if bif ();

    rtc_bus_arbiter #(.TIMEOUT_CYC(TO_CYC), .TO_W(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: who owns the bus (0 none, 1 I, 2 E, 3 L), gap cycle pending,
    // cycles already held, whether L was served last, expected Err_TO.
    int m_owner  = 0;
    bit m_gap    = 0;
    int m_held   = 0;
    bit m_last_l = 1;
    bit m_err    = 0;
    bit model_on = 0;

    function automatic bit req_of(int o);
        case (o)
            1: return bif.Inicio_I;
            2: return bif.Inicio_E;
            3: return bif.Inicio_L;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit fin_of(int o);
        case (o)
            1: return bif.Fin_I;
            2: return bif.Fin_E;
            3: return bif.Fin_L;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [13:0] model_out();
        logic [5:0] sel;
        case (m_owner)
            1: sel = {bif.Addr_I, bif.Op_I, bif.AD_I};
            2: sel = {bif.Addr_E, bif.Op_E, bif.AD_E};
            3: sel = {bif.Addr_L, bif.Op_L, bif.AD_L};
            default: sel = 6'd0;
        endcase
        return {m_owner == 1, m_owner == 2, m_owner == 3,
                bif.Final_WR && (m_owner == 1), bif.Final_WR && (m_owner == 2),
                bif.Final_WR && (m_owner == 3), sel, m_owner != 0, m_err};
    endfunction

    function automatic logic [13:0] dut_out();
        return {bif.Gnt_I, bif.Gnt_E, bif.Gnt_L, bif.Final_WR_I, bif.Final_WR_E,
                bif.Final_WR_L, bif.Addr, bif.Op, bif.AD, bif.Busy, bif.Err_TO};
    endfunction

    task automatic model_step();
        bit r, f, to;
        if (reset) begin
            m_owner = 0; m_gap = 0; m_held = 0; m_last_l = 1; m_err = 0;
        end else if (m_owner != 0) begin
            r  = req_of(m_owner);
            f  = fin_of(m_owner);
            to = (m_held == TO_CYC - 1);
            if (f || !r || to) begin
                m_err   = to && !f;
                m_owner = 0;
                m_gap   = 1;
            end else begin
                m_held++;
                m_err = 0;
            end
        end else begin
            m_err = 0;
            if (m_gap) begin
                m_gap = 0;
            end else begin
                m_held = 0;
                if (bif.Inicio_I) m_owner = 1;
                else if (bif.Inicio_E && bif.Inicio_L) m_owner = m_last_l ? 2 : 3;
                else if (bif.Inicio_E) m_owner = 2;
                else if (bif.Inicio_L) m_owner = 3;
                if (m_owner == 2) m_last_l = 0;
                if (m_owner == 3) m_last_l = 1;
            end
        end
    endtask

    // One clock: compare all outputs against the model mid-cycle, advance the
    // model with the inputs the coming edge will sample, then step past the edge.
    task automatic tick();
        logic [13:0] e_v, a_v;
        @(negedge clk);
        if (model_on) begin
            e_v = model_out();
            a_v = dut_out();
            checks++;
            if (e_v !== a_v) begin
                errors++;
                $display("FAIL model_cmp cyc=%0d got=%b want=%b (Gnt IEL,FWR IEL,Addr,Op,AD,Busy,Err)",
                         cyc, a_v, e_v);
            end
        end
        model_step();
        model_on = 1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic clear_inputs();
        bif.Inicio_I = 0; bif.Inicio_E = 0; bif.Inicio_L = 0;
        bif.Fin_I = 0; bif.Fin_E = 0; bif.Fin_L = 0;
        bif.Addr_I = 4'h1; bif.Addr_E = 4'h2; bif.Addr_L = 4'h3;
        bif.Op_I = 1; bif.Op_E = 0; bif.Op_L = 1;
        bif.AD_I = 0; bif.AD_E = 1; bif.AD_L = 1;
        bif.Final_WR = 0;
    endtask

    task automatic settle();
        clear_inputs();
        repeat (3) tick();
    endtask

    initial begin
        int g, e, hist, acnt, ord, nrec;
        int starts[4];

        reset = 1;
        clear_inputs();
        repeat (2) tick();
        chk("reset_busy", int'(bif.Busy), 0);
        chk("reset_gnt", int'({bif.Gnt_I, bif.Gnt_E, bif.Gnt_L}), 0);
        chk("reset_err", int'(bif.Err_TO), 0);
        reset = 0;
        tick();

        // Single read request, finish five cycles after the grant
        bif.Inicio_L = 1;
        g = 0; hist = 0; acnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            bif.Fin_L = 0;
            hist = hist | (int'(bif.Gnt_L) << i);
            if (bif.Addr == 4'h3) acnt++;
            if (bif.Gnt_L) begin
                g++;
                if (g == 6) begin bif.Fin_L = 1; bif.Inicio_L = 0; end
            end
        end
        chk("readonly_gnt_pattern", hist, 63);
        chk("readonly_addr_cycles", acnt, 6);
        settle();

        // All three requesting, each controller finishes and drops immediately
        bif.Inicio_I = 1; bif.Inicio_E = 1; bif.Inicio_L = 1;
        ord = 0; nrec = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            bif.Fin_I = 0; bif.Fin_E = 0; bif.Fin_L = 0;
            if (bif.Gnt_I || bif.Gnt_E || bif.Gnt_L) begin
                ord = ord * 4 + (bif.Gnt_I ? 1 : bif.Gnt_E ? 2 : 3);
                if (nrec < 4) starts[nrec] = i;
                nrec++;
                if (bif.Gnt_I) begin bif.Fin_I = 1; bif.Inicio_I = 0; end
                if (bif.Gnt_E) begin bif.Fin_E = 1; bif.Inicio_E = 0; end
                if (bif.Gnt_L) begin bif.Fin_L = 1; bif.Inicio_L = 0; end
            end
        end
        chk("prio_order_IEL", ord, 27);
        chk("prio_spacing_1", starts[1] - starts[0], 3);
        chk("prio_spacing_2", starts[2] - starts[1], 3);
        settle();

        // Write and read both held high: strict alternation
        bif.Inicio_E = 1; bif.Inicio_L = 1;
        ord = 0; nrec = 0;
        for (int i = 0; i < 40 && nrec < 4; i++) begin
            tick();
            bif.Fin_E = 0; bif.Fin_L = 0;
            if (bif.Gnt_E || bif.Gnt_L) begin
                ord = ord * 4 + (bif.Gnt_E ? 2 : 3);
                nrec++;
                if (bif.Gnt_E) bif.Fin_E = 1;
                if (bif.Gnt_L) bif.Fin_L = 1;
            end
        end
        chk("alternate_ELEL", ord, 187);
        bif.Fin_E = 0; bif.Fin_L = 0;
        // Release whichever grant may have just been issued
        for (int i = 0; i < 4 && bif.Busy; i++) begin
            bif.Inicio_E = 0; bif.Inicio_L = 0;
            tick();
        end
        settle();

        // Write held without finishing: forced release after 16 cycles
        bif.Inicio_E = 1;
        g = 0; e = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bif.Gnt_E) g++;
            if (bif.Err_TO) e++;
            if (g > 0 && !bif.Gnt_E) bif.Inicio_E = 0;
        end
        chk("timeout_hold_cycles", g, 16);
        chk("timeout_err_pulses", e, 1);
        settle();

        // Same, with the finish landing in the timeout cycle
        bif.Inicio_E = 1;
        g = 0; e = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            bif.Fin_E = 0;
            if (bif.Gnt_E) begin
                g++;
                if (g == 16) bif.Fin_E = 1;
            end
            if (bif.Err_TO) e++;
            if (g > 0 && !bif.Gnt_E) bif.Inicio_E = 0;
        end
        chk("fin_at_timeout_hold", g, 16);
        chk("fin_at_timeout_err", e, 0);
        settle();

        // Final_WR routing during a read grant and in IDLE; foreign Fin ignored
        bif.Inicio_L = 1;
        for (int i = 0; i < 10 && !bif.Gnt_L; i++) tick();
        chk("fwr_read_granted", int'(bif.Gnt_L), 1);
        bif.Final_WR = 1;
        bif.Fin_E    = 1;
        #1;
        chk("fwr_routed", int'({bif.Final_WR_I, bif.Final_WR_E, bif.Final_WR_L}), 1);
        tick();
        bif.Final_WR = 0;
        bif.Fin_E    = 0;
        chk("foreign_fin_ignored", int'(bif.Gnt_L), 1);
        bif.Fin_L = 1;
        tick();
        bif.Fin_L = 0;
        bif.Inicio_L = 0;
        tick();
        bif.Final_WR = 1;
        #1;
        chk("fwr_idle_dropped", int'({bif.Final_WR_I, bif.Final_WR_E, bif.Final_WR_L}), 0);
        tick();
        bif.Final_WR = 0;
        settle();

        // Abort: request drops mid-grant
        bif.Inicio_L = 1;
        for (int i = 0; i < 10 && !bif.Gnt_L; i++) tick();
        bif.Inicio_L = 0;
        tick();
        chk("abort_release", int'({bif.Gnt_L, bif.Busy}), 0);
        settle();

        // Reset during a write grant, then both pending after reset
        bif.Inicio_E = 1;
        for (int i = 0; i < 10 && !bif.Gnt_E; i++) tick();
        repeat (2) tick();
        reset = 1;
        bif.Inicio_L = 1;
        tick();
        chk("reset_midgrant_outputs", int'(dut_out()), 0);
        tick();
        reset = 0;
        tick();
        chk("post_reset_write_first", int'({bif.Gnt_E, bif.Gnt_L}), 2);
        settle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if (bif.Inicio_I) bif.Inicio_I = ($urandom_range(39) != 0);
            else              bif.Inicio_I = ($urandom_range(15) == 0);
            if (bif.Inicio_E) bif.Inicio_E = ($urandom_range(39) != 0);
            else              bif.Inicio_E = ($urandom_range(5) == 0);
            if (bif.Inicio_L) bif.Inicio_L = ($urandom_range(39) != 0);
            else              bif.Inicio_L = ($urandom_range(5) == 0);
            bif.Fin_I = ($urandom_range(9) == 0);
            bif.Fin_E = ($urandom_range(9) == 0);
            bif.Fin_L = ($urandom_range(9) == 0);
            bif.Final_WR = ($urandom_range(3) == 0);
            bif.Addr_I = 4'($urandom); bif.Addr_E = 4'($urandom); bif.Addr_L = 4'($urandom);
            bif.Op_I = 1'($urandom); bif.Op_E = 1'($urandom); bif.Op_L = 1'($urandom);
            bif.AD_I = 1'($urandom); bif.AD_E = 1'($urandom); bif.AD_L = 1'($urandom);
            reset = ($urandom_range(499) == 0);
            tick();
        end
        reset = 0;
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtc_bus_arbiter.md
RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: maximum cycles a grant may be held before forced release.
REQ-002 Parameter TO_W, default 11: width of the timeout counter; SHALL satisfy 2^TO_W > TIMEOUT_CYC.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Inicio_I, Inicio_E, Inicio_L  in  1 each  request levels from the init, write and read controllers; held high until done.
REQ-006 Fin_I, Fin_E, Fin_L  in  1 each  one-cycle completion pulses from the corresponding controllers.
REQ-007 Addr_I, Addr_E, Addr_L  in  4 each  bus address from each controller.
REQ-008 Op_I/Op_E/Op_L, AD_I/AD_E/AD_L  in  1 each  operation and address/data strobe from each controller.
REQ-009 Final_WR  in  1  bus-cycle-done pulse from the shared bus-cycle engine.
REQ-010 Gnt_I, Gnt_E, Gnt_L  out  1 each  registered, one-hot-or-zero grants.
REQ-011 Final_WR_I, Final_WR_E, Final_WR_L  out  1 each  Final_WR routed to the granted controller only.
REQ-012 Addr  out  4, Op  out  1, AD  out  1  muxed signals to the bus-cycle engine.
REQ-013 Busy  out  1  high in any grant state.
REQ-014 Err_TO  out  1  one-cycle pulse on timeout release.

Function
REQ-015 FSM states SHALL be IDLE, G_INIT, G_WRITE, G_READ and GAP.
REQ-016 IDLE: if Inicio_I, go to G_INIT; else if Inicio_E and Inicio_L are both high, grant the one not served last; else grant whichever of Inicio_E or Inicio_L is high; with no request, stay in IDLE.
REQ-017 The last-served flag SHALL be 1 bit, set to E or L on entry to G_WRITE or G_READ respectively, and left unchanged by G_INIT.
REQ-018 Gnt_x SHALL be high exactly while in state G_x, so the grant appears one cycle after the request is sampled in IDLE.
REQ-019 In G_x, the FSM SHALL leave to GAP on the cycle after Fin_x=1, after Inicio_x drops to 0 (abort), or at timeout, whichever occurs first.
REQ-020 GAP SHALL last exactly 1 cycle with all grants low, then go to IDLE, so consecutive grants are separated by at least 2 cycles.
REQ-021 Addr/Op/AD SHALL combinationally follow the granted controller's inputs; in IDLE or GAP they SHALL be Addr=4'h0, Op=0, AD=0.
REQ-022 Final_WR_x SHALL equal Final_WR AND Gnt_x; Final_WR outside a grant SHALL be dropped.
REQ-023 The timeout counter SHALL clear on grant entry and increment each cycle in a grant state.
REQ-024 When the counter reaches TIMEOUT_CYC-1 without Fin_x, the FSM SHALL go to GAP and Err_TO SHALL pulse for that transition cycle.
REQ-025 If Fin_x and timeout occur in the same cycle, Fin_x SHALL win and Err_TO SHALL stay 0.
REQ-026 A Fin_y pulse from a non-granted controller SHALL be ignored.
REQ-027 A requester whose Inicio stays high after release SHALL be re-arbitrated normally from IDLE.

Reset
REQ-028 While reset=1, the FSM SHALL go to IDLE, the counter SHALL clear, the last-served flag SHALL be set to L, and all grants, Final_WR_x, Busy and Err_TO SHALL be 0.
REQ-029 Reset asserted mid-grant SHALL take effect on the next edge with no Err_TO pulse.

Verification
REQ-030 Inicio_L=1 alone, Fin_L pulsed 5 cycles after grant -> Gnt_L high from cycle 1 for 6 cycles, GAP for 1 cycle, then IDLE; Addr tracks Addr_L=4'h3 during the grant.
REQ-031 Inicio_I, Inicio_E and Inicio_L all high at once -> order of grants is I, then E, then L, with a 2-cycle gap between grants.
REQ-032 Inicio_E and Inicio_L held high, each finishing immediately -> grants alternate E, L, E, L.
REQ-033 Gnt_E held with no Fin_E and TIMEOUT_CYC=16 -> release at cycle 16 and one Err_TO pulse; same stimulus with Fin_E also at cycle 16 -> no Err_TO.
REQ-034 Final_WR pulsed during G_READ and during IDLE -> Final_WR_L=1 only for the first pulse; the IDLE pulse appears on no output.
REQ-035 reset=1 asserted during G_WRITE -> all outputs 0 next cycle; after reset, with Inicio_E and Inicio_L both high, E is granted first.
